// File: rtl/lsu_datamem.sv
// Byte-addressed data memory for the load/store path: sub-word access,
// registered responses and optional splitting of misaligned accesses.
module lsu_datamem #(
    parameter int DEPTH          = 2048,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t state, state_d;

    logic [31:0] mem [DEPTH];

    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [3:0]       len;
    logic [7:0]       mask8;
    logic [63:0]      data64;
    logic             illegal, misal, err_c, split_c, accept;

    logic [IDX_W-1:0] maddr;
    logic             we;
    logic [3:0]       wmask;
    logic [31:0]      wbytes;
    logic [31:0]      rword;

    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_off;
    logic [2:0]       r_f3;
    logic             r_wren;
    logic [3:0]       r_mask_hi;
    logic [31:0]      r_wdata_hi;
    logic [31:0]      r_lo;

    logic unused_addr;
    assign unused_addr = ^i_addr[31:IDX_W+2];

    // Shift the word pair right to the access offset, then extend by size.
    function automatic logic [31:0] extend(input logic [2:0]  f3,
                                           input logic [63:0] dw,
                                           input logic [1:0]  sh);
        logic [31:0] v;
        v = 32'(dw >> {sh, 3'b000});
        case (f3[1:0])
            2'd0:    extend = f3[2] ? {24'b0, v[7:0]}
                                    : {{24{v[7]}}, v[7:0]};
            2'd1:    extend = f3[2] ? {16'b0, v[15:0]}
                                    : {{16{v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign o_req_ready = (state == IDLE) && !i_rst;
    assign accept      = i_req_valid && o_req_ready;

    always_comb begin
        off = i_addr[1:0];
        idx = i_addr[IDX_W+1:2];
        if (i_wren)
            illegal = (i_funct3 > 3'd2);
        else
            illegal = (i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11);
        misal = ((i_funct3[1:0] == 2'd1) && (off == 2'd3)) ||
                ((i_funct3[1:0] == 2'd2) && (off != 2'd0));
        case (i_funct3[1:0])
            2'd0:    len = 4'b0001;
            2'd1:    len = 4'b0011;
            default: len = 4'b1111;
        endcase
        err_c   = illegal || (misal && !MISALIGN_SPLIT);
        split_c = !illegal && misal && MISALIGN_SPLIT;
        // Lanes [3:0] hit word idx, lanes [7:4] spill into word idx+1.
        mask8   = {4'b0, len} << off;
        data64  = {32'b0, i_wdata} << {off, 3'b000};
    end

    always_comb begin
        if (state == SPLIT) begin
            maddr  = r_idx + IDX_W'(1);
            we     = !i_rst && r_wren;
            wmask  = r_mask_hi;
            wbytes = r_wdata_hi;
        end else begin
            maddr  = idx;
            we     = accept && i_wren && !err_c;
            wmask  = mask8[3:0];
            wbytes = data64[31:0];
        end
        rword = mem[maddr];
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b])
                    mem[maddr][8*b +: 8] <= wbytes[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (accept && split_c) state_d = SPLIT;
            SPLIT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_rdata     <= '0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_d;
            o_rsp_valid <= 1'b0;
            if (state == SPLIT) begin
                o_rsp_valid <= 1'b1;
                o_err       <= 1'b0;
                o_rdata     <= r_wren ? '0
                                      : extend(r_f3, {rword, r_lo}, r_off);
            end else if (accept) begin
                if (err_c) begin
                    o_rsp_valid <= 1'b1;
                    o_err       <= 1'b1;
                    o_rdata     <= '0;
                end else if (split_c) begin
                    r_idx      <= idx;
                    r_off      <= off;
                    r_f3       <= i_funct3;
                    r_wren     <= i_wren;
                    r_mask_hi  <= mask8[7:4];
                    r_wdata_hi <= data64[63:32];
                    r_lo       <= rword;
                end else begin
                    o_rsp_valid <= 1'b1;
                    o_err       <= 1'b0;
                    o_rdata     <= i_wren ? '0
                                          : extend(i_funct3, {32'b0, rword}, off);
                end
            end
        end
    end

endmodule

// File: doc/lsu_datamem.md
Name: lsu_datamem

Overview:
Parametrised byte-addressed data memory for the single-cycle RISC-V core's load/store path.
- Adds RISC-V sub-word access (LB/LH/LW/LBU/LHU/SB/SH/SW), byte-lane write strobes and sign/zero extension.
- Adds registered (synchronous) read data with a valid/ready request/response handshake.
- Adds optional hardware splitting of misaligned accesses into two word accesses.
- Sits between the execute stage and the core's data-side address decode.

Parameters:
DEPTH, 2048, number of 32-bit words; power of two, >= 4.
IDX_W, $clog2(DEPTH), word index width (derived; not overridden).
MISALIGN_SPLIT, 1, 1 = misaligned accesses split into two word accesses; 0 = misaligned accesses return an error.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst  in  1  synchronous reset, active-high.
i_req_valid  in  1  request present.
o_req_ready  out  1  request accepted when i_req_valid && o_req_ready.
i_wren  in  1  1 = store, 0 = load.
i_funct3  in  3  RISC-V funct3: 0=B, 1=H, 2=W, 4=BU, 5=HU; loads only for 4/5.
i_addr  in  32  byte address; word index = i_addr[IDX_W+1:2]; upper bits ignored (alias).
i_wdata  in  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
o_rsp_valid  out  1  one-cycle response pulse.
o_rdata  out  32  load result, extended; 0 for stores and errors.
o_err  out  1  qualifies o_rsp_valid: illegal funct3, or misaligned with MISALIGN_SPLIT=0.

Behaviour:
- Reset (i_rst=1 at an edge):
  - state <= IDLE; o_rsp_valid, o_rdata, o_err <= 0.
  - Memory contents are not cleared.
  - Reset overrides any same-cycle request: no write, no response.
- o_req_ready = (state==IDLE) && !i_rst.
- Byte offset off = i_addr[1:0].
- Misaligned: H/HU with off==3; W with off!=0. Byte accesses are never misaligned.
- Illegal funct3:
  - Loads: 3, 6, 7. Stores: any value other than 0, 1, 2.
  - Illegal funct3 takes priority over the misalign check.
- FSM states: IDLE, SPLIT.
- IDLE, accept, aligned legal request:
  - Store: at the accept edge, write the byte lanes selected by size/off, with data shifted to lane off.
  - Load: at the accept edge, register the extracted, extended lane(s) into o_rdata.
  - o_rsp_valid=1 in the following cycle (latency 1); state stays IDLE, so back-to-back accepts give one response per cycle.
- IDLE, accept, misaligned, MISALIGN_SPLIT=1:
  - At the accept edge, access word idx with the low-part lanes: store writes them, load captures them into an internal buffer.
  - Latch the request; state <= SPLIT; o_req_ready=0 for one cycle.
- SPLIT (one cycle):
  - Access word (idx+1) mod DEPTH with the remaining lanes. Index wrap from DEPTH-1 to 0 is required.
  - Load: o_rdata <= merged, extended value. o_rsp_valid=1 next cycle; state <= IDLE.
  - Total latency 2 cycles from accept.
- Misaligned with MISALIGN_SPLIT=0, or illegal funct3: no memory access; next cycle o_rsp_valid=1, o_err=1, o_rdata=0.
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
- o_rdata holds its last value when o_rsp_valid=0. o_err is 0 on every non-error response.
- Store then load to the same word on consecutive accepts: the load returns the new data (write committed at the prior edge).
- Reset asserted during SPLIT:
  - Abort; the second word is not written and no response is issued.
  - The first-word partial store remains in memory.
- Requests with i_req_valid=1 while o_req_ready=0 are ignored. The requester holds the request until accepted.

Test Plan:
- SW 0xDEADBEEF @0x10; LW @0x10 -> rsp 1 cycle after each accept; rdata 0xDEADBEEF, err=0. LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
- SH 0x8001 @0x22 over word 0; LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001; LW @0x20 -> 0x80010000 (lower half untouched).
- MISALIGN_SPLIT=1: SW 0x11223344 @0x05 -> ready low 1 cycle, rsp at +2. LW @0x05 -> 0x11223344. LW @0x04 -> 0x223344xx (byte 4 unchanged); word @0x08 low byte = 0x11.
- Wrap: LW @ byte addr 4*DEPTH-2 after writing 0xAABB into the last word's top half and 0xCCDD into word 0's low half -> 0xCCDDAABB.
- MISALIGN_SPLIT=0: LW @0x02 -> err=1, rdata=0, memory unchanged. Any mode: load funct3=3 -> err=1; store funct3=4 -> err=1, no write.
- Reset mid-SPLIT during misaligned SW @0x07 -> no rsp, word @0x04 byte 3 updated, word @0x08 unchanged; outputs 0, ready=1 in the cycle after reset deasserts.
